// File: rtl/icache_pkg.sv
// Shared types and helpers for the set-associative instruction cache.
package icache_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REFILL = 2'd1,
    S_FLUSH  = 2'd2
  } state_e;

  // Bit width needed to index n entries; never below 1 so vectors stay legal.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/icache_way.sv
// One cache way: per-set data, tag and valid with a combinational read port
// and a synchronous line-write / invalidate-all port.
module icache_way
  import icache_pkg::*;
#(
  parameter int WPB   = 4,
  parameter int SETS  = 8,
  parameter int TAG_W = 25,
  parameter int IDX_W = 3,
  parameter int OFF_W = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [IDX_W-1:0]   rd_index_i,
  input  logic [TAG_W-1:0]   rd_tag_i,
  input  logic [OFF_W-1:0]   rd_offset_i,
  output logic               valid_o,
  output logic               match_o,
  output logic [31:0]        word_o,
  input  logic               wr_en_i,
  input  logic [IDX_W-1:0]   wr_index_i,
  input  logic [TAG_W-1:0]   wr_tag_i,
  input  logic [32*WPB-1:0]  wr_data_i,
  input  logic               inv_all_i
);

  logic [32*WPB-1:0] data_q [SETS];
  logic [TAG_W-1:0]  tag_q  [SETS];
  logic [SETS-1:0]   valid_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
    end else if (inv_all_i) begin
      valid_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_index_i] <= 1'b1;
    end
  end

  // Payload needs no reset: it is only observed through a valid bit.
  always_ff @(posedge clock) begin
    if (wr_en_i) begin
      data_q[wr_index_i] <= wr_data_i;
      tag_q[wr_index_i]  <= wr_tag_i;
    end
  end

  assign valid_o = valid_q[rd_index_i];
  assign match_o = valid_q[rd_index_i] && (tag_q[rd_index_i] == rd_tag_i);
  assign word_o  = data_q[rd_index_i][{rd_offset_i, 5'b0} +: 32];

endmodule

// File: rtl/icache_assoc.sv
// 1- or 2-way instruction cache with pseudo-LRU, integrated refill FSM and flush.
// Optional performance counters are enabled by defining ICACHE_PERF_EN.
module icache_assoc
  import icache_pkg::*;
#(
  parameter int ADDR_W          = 32,
  parameter int WORDS_PER_BLOCK = 4,
  parameter int SETS            = 8,
  parameter int WAYS            = 2,
  parameter int MEM_ADDR_W      = ADDR_W - $clog2(WORDS_PER_BLOCK * 4)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [ADDR_W-1:0]            pc,
  input  logic                         pc_valid,
  input  logic                         flush,
  output logic [31:0]                  instruction,
  output logic                         busywait,
  output logic                         hit,
  output logic                         mem_read,
  output logic [MEM_ADDR_W-1:0]        mem_address,
  input  logic [32*WORDS_PER_BLOCK-1:0] mem_readdata,
  input  logic                         mem_busywait,
  output logic [31:0]                  hit_count,
  output logic [31:0]                  miss_count
);

  localparam int OFF_W = width_of(WORDS_PER_BLOCK);
  localparam int IDX_W = width_of(SETS);
  localparam int TAG_W = ADDR_W - OFF_W - IDX_W - 2;

  if (WAYS != 1 && WAYS != 2) begin : g_bad_ways
    $error("icache_assoc: WAYS must be 1 or 2");
  end
  if (MEM_ADDR_W != TAG_W + IDX_W) begin : g_bad_maddr
    $error("icache_assoc: MEM_ADDR_W must equal tag + index width");
  end

  logic [OFF_W-1:0] off;
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  assign off = pc[2 +: OFF_W];
  assign idx = pc[OFF_W+2 +: IDX_W];
  assign tag = pc[ADDR_W-1 -: TAG_W];

  state_e           state_q, state_d;
  logic [TAG_W-1:0] rtag_q, rtag_d;
  logic [IDX_W-1:0] ridx_q, ridx_d;
  logic             victim_q, victim_d;
  logic             fpend_q, fpend_d;
  logic [SETS-1:0]  lru_q, lru_d;

  logic             refill_we, inv_all, hit_evt, miss_evt, victim;
  logic [WAYS-1:0]  way_vld, way_match;
  logic [31:0]      way_word [WAYS];

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    icache_way #(
      .WPB(WORDS_PER_BLOCK), .SETS(SETS), .TAG_W(TAG_W), .IDX_W(IDX_W), .OFF_W(OFF_W)
    ) u_way (
      .clock      (clock),
      .reset      (reset),
      .rd_index_i (idx),
      .rd_tag_i   (tag),
      .rd_offset_i(off),
      .valid_o    (way_vld[w]),
      .match_o    (way_match[w]),
      .word_o     (way_word[w]),
      .wr_en_i    (refill_we && (victim_q == 1'(w))),
      .wr_index_i (ridx_q),
      .wr_tag_i   (rtag_q),
      .wr_data_i  (mem_readdata),
      .inv_all_i  (inv_all)
    );
  end

  always_comb begin
    hit         = pc_valid & (|way_match);
    instruction = way_word[0];
    if (WAYS == 2 && way_match[WAYS-1]) instruction = way_word[WAYS-1];
    // Fill an empty way before evicting; way 0 wins among empties.
    victim = 1'b0;
    if (WAYS == 2) begin
      if (!way_vld[0])           victim = 1'b0;
      else if (!way_vld[WAYS-1]) victim = 1'b1;
      else                       victim = lru_q[idx];
    end
  end

  always_comb begin
    state_d   = state_q;
    rtag_d    = rtag_q;
    ridx_d    = ridx_q;
    victim_d  = victim_q;
    fpend_d   = fpend_q;
    lru_d     = lru_q;
    busywait  = 1'b0;
    mem_read  = 1'b0;
    refill_we = 1'b0;
    inv_all   = 1'b0;
    hit_evt   = 1'b0;
    miss_evt  = 1'b0;
    case (state_q)
      S_IDLE: begin
        busywait = pc_valid & ~hit;
        hit_evt  = pc_valid & hit;
        if (flush) begin
          state_d = S_FLUSH;
        end else if (pc_valid && !hit) begin
          state_d  = S_REFILL;
          rtag_d   = tag;
          ridx_d   = idx;
          victim_d = victim;
          miss_evt = 1'b1;
        end else if (hit && WAYS == 2) begin
          lru_d[idx] = way_match[0];
        end
      end
      S_REFILL: begin
        busywait = 1'b1;
        mem_read = 1'b1;
        if (flush) fpend_d = 1'b1;
        if (!mem_busywait) begin
          refill_we = 1'b1;
          if (WAYS == 2) lru_d[ridx_q] = ~victim_q;
          // A flush seen during the refill must still wipe the new line.
          state_d = (fpend_q || flush) ? S_FLUSH : S_IDLE;
          fpend_d = 1'b0;
        end
      end
      S_FLUSH: begin
        busywait = 1'b1;
        inv_all  = 1'b1;
        lru_d    = '0;
        fpend_d  = 1'b0;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      rtag_q   <= '0;
      ridx_q   <= '0;
      victim_q <= 1'b0;
      fpend_q  <= 1'b0;
      lru_q    <= '0;
    end else begin
      state_q  <= state_d;
      rtag_q   <= rtag_d;
      ridx_q   <= ridx_d;
      victim_q <= victim_d;
      fpend_q  <= fpend_d;
      lru_q    <= lru_d;
    end
  end

  assign mem_address = {rtag_q, ridx_q};

`ifdef ICACHE_PERF_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (hit_evt && hit_cnt_q != 32'hFFFF_FFFF)   hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (miss_evt && miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;

  logic unused_sig;
  assign unused_sig = ^pc[1:0];
`else
  assign hit_count  = '0;
  assign miss_count = '0;

  logic unused_sig;
  assign unused_sig = ^{pc[1:0], hit_evt, miss_evt};
`endif

endmodule
